// File: rtl/ifetch_pkg.sv
// Shared widths, reset base and fetch-entry layout for the instruction fetch front end.
package ifetch_pkg;

  localparam int SYS_ADDR_SPACE = 32;
  localparam int INST_WIDTH     = 32;

  localparam logic [SYS_ADDR_SPACE-1:0] MEM_BASE   = 32'h0000_0000;
  localparam logic [SYS_ADDR_SPACE-1:0] INST_BYTES = 32'd4;

  // One FIFO slot: the PC travels alongside the instruction it fetched.
  typedef struct packed {
    logic [SYS_ADDR_SPACE-1:0] pc;
    logic [INST_WIDTH-1:0]     inst;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  // Redirect targets are forced onto a word boundary; misalignment is not trapped here.
  function automatic logic [SYS_ADDR_SPACE-1:0] align_word(input logic [SYS_ADDR_SPACE-1:0] addr);
    return {addr[SYS_ADDR_SPACE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small skid FIFO holding {pc, inst} pairs between the ROM response and decode.
// Head data reads as zero while empty; flush empties it in one cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [CW-1:0]          count,
  output logic [ENTRY_WIDTH-1:0] head
);

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; flush discards everything queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC generation, ROM request issue, one outstanding
// read tracked across the ROM's 1-cycle latency, and redirect with full flush.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [SYS_ADDR_SPACE-1:0] RESET_PC = MEM_BASE,
  parameter int                        DEPTH    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      redirect_i,
  input  logic [SYS_ADDR_SPACE-1:0] redirect_pc_i,
  output logic                      rom_re_o,
  output logic [SYS_ADDR_SPACE-1:0] rom_addr_o,
  input  logic [INST_WIDTH-1:0]     rom_inst_i,
  output logic                      inst_valid_o,
  input  logic                      inst_ready_i,
  output logic [INST_WIDTH-1:0]     inst_o,
  output logic [SYS_ADDR_SPACE-1:0] pc_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [SYS_ADDR_SPACE-1:0] pc_q;
  logic [SYS_ADDR_SPACE-1:0] inflight_pc_q;
  logic                      inflight_q;

  logic [CW-1:0]             fifo_count;
  logic [ENTRY_WIDTH-1:0]    fifo_head;
  fetch_entry_t              head_entry;
  fetch_entry_t              resp_entry;

  logic [SYS_ADDR_SPACE-1:0] target;
  logic [OW-1:0]             occupancy;
  logic                      pop;
  logic                      push;
  logic                      issue;

  assign target = align_word(redirect_pc_i);

  // Redirect hides the head so decode never takes a stale instruction.
  assign inst_valid_o = (fifo_count != '0) & ~redirect_i;
  assign pop          = inst_valid_o & inst_ready_i;

  // Every outstanding read reserves a FIFO slot, so a response always fits.
  assign occupancy = {1'b0, fifo_count} + OW'(inflight_q) - OW'(pop);
  assign issue     = rst_ni & (redirect_i | (occupancy < OW'(DEPTH)));

  assign rom_re_o   = issue;
  assign rom_addr_o = redirect_i ? target : pc_q;

  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign push                = inflight_q & ~redirect_i;
  assign resp_entry.pc       = inflight_pc_q;
  assign resp_entry.inst     = rom_inst_i;

  // PC advance and in-flight tracking; redirect restarts the stream at the aligned target.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (redirect_i) begin
        inflight_pc_q <= target;
        pc_q          <= target + INST_BYTES;
      end else if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + INST_BYTES;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (resp_entry),
    .pop    (pop),
    .flush  (redirect_i),
    .count  (fifo_count),
    .head   (fifo_head)
  );

  assign head_entry = fetch_entry_t'(fifo_head);
  assign inst_o     = head_entry.inst;
  assign pc_o       = head_entry.pc;

endmodule
